// File: rtl/dma_periph_responder.sv
// dma_periph_responder: single-channel DMA peripheral endpoint with a data FIFO.
// Raises DREQ toward an 8237A-style controller, answers IOR_N/IOW_N strobes under
// DACK_N, and buffers data between the DMA bus and the device core.
// Optional feature macro: DMA_PERIPH_EOP_GEN_EN (adds tc_count and EOP generation).
// Ports:
//   CLK, RESET_N                 clock, async active-low reset
//   en, dir, demand              channel enable, direction (0 dev->mem, 1 mem->dev), demand mode
//   DREQ, DACK_N                 DMA request / acknowledge
//   IOR_N, IOW_N                 bus read / write strobes
//   DB_I, DB_O, DB_OE            shared data bus
//   EOP_N_I, EOP_N_O             end-of-process in / open-drain emulation out
//   src_valid/ready/data         core push side (dir=0)
//   snk_valid/ready/data         core pop side (dir=1)
//   tc_done, err, level          sticky EOP flag, sticky under/overrun flag, FIFO occupancy
//   tc_count                     transfer count, only with DMA_PERIPH_EOP_GEN_EN
module dma_periph_responder #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          en,
    input  logic          dir,
    input  logic          demand,
    output logic          DREQ,
    input  logic          DACK_N,
    input  logic          IOR_N,
    input  logic          IOW_N,
    input  logic [DW-1:0] DB_I,
    output logic [DW-1:0] DB_O,
    output logic          DB_OE,
    input  logic          EOP_N_I,
    output logic          EOP_N_O,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic [DW-1:0] src_data,
    output logic          snk_valid,
    input  logic          snk_ready,
    output logic [DW-1:0] snk_data,
    output logic          tc_done,
    output logic          err,
    output logic [AW:0]   level
`ifdef DMA_PERIPH_EOP_GEN_EN
    ,
    input  logic [15:0]   tc_count
`endif
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, ACK, STB} stateT;

    stateT         state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   levelQ;
    logic          dirQ;
    logic          iorPrev, iowPrev;
    logic          readEmptyQ;
    logic [DW-1:0] wrData;
    logic          tcDone, errQ;

    logic fifoEmpty, fifoFull, reqCond, reqCondIdle;
    logic dackOn, eopOn;
    logic iorFall, iorRise, iowFall, iowRise, stbFall, stbRise;
    logic busPush, busPop, corePush, corePop, doPush, doPop;
    logic tcHit;

    // Status and bus-event decode
    assign fifoEmpty   = (levelQ == '0);
    assign fifoFull    = (levelQ == DEPTH_L);
    assign reqCond     = dirQ ? !fifoFull : !fifoEmpty;
    assign reqCondIdle = dir  ? !fifoFull : !fifoEmpty;
    assign dackOn      = !DACK_N;
    assign eopOn       = !EOP_N_I && !DACK_N;
    assign iorFall     = iorPrev && !IOR_N;
    assign iorRise     = !iorPrev && IOR_N;
    assign iowFall     = iowPrev && !IOW_N;
    assign iowRise     = !iowPrev && IOW_N;
    assign stbFall     = dirQ ? iowFall : iorFall;
    assign stbRise     = dirQ ? iowRise : iorRise;

    // FIFO access: bus side only completes on a strobe rising edge in STB
    assign busPush  = (state == STB) && dirQ && iowRise && !fifoFull;
    assign busPop   = (state == STB) && !dirQ && iorRise && !readEmptyQ;
    assign corePush = src_valid && src_ready;
    assign corePop  = snk_valid && snk_ready;
    assign doPush   = busPush || corePush;
    assign doPop    = busPop || corePop;

    assign src_ready = !dirQ && !fifoFull;
    assign snk_valid = dirQ && !fifoEmpty;
    assign snk_data  = mem[rdPtr];
    assign level     = levelQ;
    assign tc_done   = tcDone;
    assign err       = errQ;

`ifdef DMA_PERIPH_EOP_GEN_EN
    logic [15:0] tcCnt;
    logic        eopNQ;
    // Counter is at 1 on the strobe that takes it to zero; 0 loaded means 65536
    assign tcHit   = stbRise && (tcCnt == 16'd1);
    assign EOP_N_O = eopNQ;
`else
    assign tcHit   = 1'b0;
    assign EOP_N_O = 1'b1;
`endif

    // FIFO storage (no reset needed on the data array)
    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr] <= dirQ ? wrData : src_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            levelQ <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            levelQ <= levelQ + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    // Transfer state machine with registered bus outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            DREQ       <= 1'b0;
            DB_OE      <= 1'b0;
            DB_O       <= '0;
            dirQ       <= 1'b0;
            iorPrev    <= 1'b1;
            iowPrev    <= 1'b1;
            readEmptyQ <= 1'b0;
            wrData     <= '0;
            tcDone     <= 1'b0;
            errQ       <= 1'b0;
`ifdef DMA_PERIPH_EOP_GEN_EN
            tcCnt      <= '0;
            eopNQ      <= 1'b1;
`endif
        end else begin
            iorPrev <= IOR_N;
            iowPrev <= IOW_N;
            if (!IOW_N) wrData <= DB_I;
`ifdef DMA_PERIPH_EOP_GEN_EN
            eopNQ <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    DREQ  <= 1'b0;
                    DB_OE <= 1'b0;
                    // dir follows the core while idle so its FIFO side can prefill;
                    // it is frozen from the request onward
                    dirQ  <= dir;
                    if (!en) begin
                        tcDone <= 1'b0;
                        errQ   <= 1'b0;
                    end else if (!tcDone && reqCondIdle) begin
                        state <= REQ;
                        DREQ  <= 1'b1;
`ifdef DMA_PERIPH_EOP_GEN_EN
                        tcCnt <= tc_count;
`endif
                    end
                end
                REQ: begin
                    if (!en) begin
                        state <= IDLE;
                        DREQ  <= 1'b0;
                    end else if (dackOn) begin
                        if (eopOn) begin
                            tcDone <= 1'b1;
                            DREQ   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= ACK;
                            DREQ  <= demand && reqCond;
                        end
                    end
                end
                ACK: begin
                    if (eopOn) begin
                        tcDone <= 1'b1;
                        DREQ   <= 1'b0;
                        state  <= IDLE;
                    end else if (dackOn && stbFall) begin
                        state <= STB;
                        DREQ  <= demand && en && reqCond;
                        if (!dirQ) begin
                            DB_OE      <= 1'b1;
                            readEmptyQ <= fifoEmpty;
                            if (fifoEmpty) begin
                                DB_O <= '1;
                                errQ <= 1'b1;
                            end else begin
                                DB_O <= mem[rdPtr];
                            end
                        end
                    end else if (!dackOn || !en) begin
                        state <= IDLE;
                        DREQ  <= 1'b0;
                    end else begin
                        DREQ <= demand && reqCond;
                    end
                end
                STB: begin
                    if (eopOn) begin
                        tcDone <= 1'b1;
                        DREQ   <= 1'b0;
                    end
                    if (stbRise) begin
                        DB_OE <= 1'b0;
                        if (dirQ && fifoFull) errQ <= 1'b1;
`ifdef DMA_PERIPH_EOP_GEN_EN
                        tcCnt <= tcCnt - 16'd1;
                        if (tcHit) begin
                            eopNQ  <= 1'b0;
                            tcDone <= 1'b1;
                        end
`endif
                        // Continuation judged on pre-transfer occupancy; DREQ lags one cycle
                        if (demand && en && reqCond && !tcDone && !eopOn && !tcHit) begin
                            state <= ACK;
                            DREQ  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            DREQ  <= 1'b0;
                        end
                    end else if (!eopOn && !tcDone) begin
                        DREQ <= demand && en && reqCond;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_periph_responder.sv
// Directed self-checking bench for dma_periph_responder (DW=8, DEPTH=8).
module tb_dma_periph_responder;

    logic       CLK, RESET_N;
    logic       en, dir, demand;
    logic       DREQ, DACK_N, IOR_N, IOW_N;
    logic [7:0] DB_I, DB_O;
    logic       DB_OE;
    logic       EOP_N_I, EOP_N_O;
    logic       src_valid, src_ready;
    logic [7:0] src_data;
    logic       snk_valid, snk_ready;
    logic [7:0] snk_data;
    logic       tc_done, err;
    logic [3:0] level;
`ifdef DMA_PERIPH_EOP_GEN_EN
    logic [15:0] tc_count;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    dma_periph_responder #(.DW(8), .DEPTH(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .en(en), .dir(dir), .demand(demand),
        .DREQ(DREQ), .DACK_N(DACK_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .DB_I(DB_I), .DB_O(DB_O), .DB_OE(DB_OE),
        .EOP_N_I(EOP_N_I), .EOP_N_O(EOP_N_O),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
        .tc_done(tc_done), .err(err), .level(level)
`ifdef DMA_PERIPH_EOP_GEN_EN
        , .tc_count(tc_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic corePush(input logic [7:0] d);
        src_valid = 1'b1;
        src_data  = d;
        tick();
        src_valid = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; en = 1'b0; dir = 1'b0; demand = 1'b0;
        DACK_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N_I = 1'b1;
        DB_I = 8'h00; src_valid = 1'b0; src_data = 8'h00; snk_ready = 1'b0;
`ifdef DMA_PERIPH_EOP_GEN_EN
        tc_count = 16'd0;
`endif
        repeat (3) tick();
        checkEq("rst_dreq", DREQ, 0);
        checkEq("rst_dboe", DB_OE, 0);
        checkEq("rst_dbo", DB_O, 0);
        checkEq("rst_eopo", EOP_N_O, 1);
        checkEq("rst_tc", tc_done, 0);
        checkEq("rst_err", err, 0);
        checkEq("rst_level", level, 0);
        checkEq("rst_snkv", snk_valid, 0);
        RESET_N = 1'b1;
        tick();

        // Single-mode read
        corePush(8'hA5);
        corePush(8'h3C);
        checkEq("rd_level2", level, 2);
        en = 1'b1;
        tick();
        checkEq("rd_dreq_up", DREQ, 1);
        DACK_N = 1'b0;
        tick();
        checkEq("rd_dreq_drop", DREQ, 0);
        IOR_N = 1'b0;
        tick();
        checkEq("rd_dboe", DB_OE, 1);
        checkEq("rd_dbo_a5", DB_O, 8'hA5);
        tick();
        checkEq("rd_dbo_hold", DB_O, 8'hA5);
        IOR_N = 1'b1; DACK_N = 1'b1;
        tick();
        checkEq("rd_dboe_off", DB_OE, 0);
        checkEq("rd_level1", level, 1);
        tick();
        checkEq("rd_dreq_again", DREQ, 1);

        // External EOP during the second read strobe
        DACK_N = 1'b0;
        tick();
        IOR_N = 1'b0;
        tick();
        checkEq("eop_dbo_3c", DB_O, 8'h3C);
        EOP_N_I = 1'b0;
        tick();
        checkEq("eop_tc", tc_done, 1);
        checkEq("eop_dreq", DREQ, 0);
        EOP_N_I = 1'b1; IOR_N = 1'b1; DACK_N = 1'b1;
        tick();
        checkEq("eop_popped", level, 0);
        checkEq("eop_dboe", DB_OE, 0);
        corePush(8'h5A);
        repeat (3) tick();
        checkEq("eop_no_dreq", DREQ, 0);
        en = 1'b0;
        tick();
        checkEq("eop_tc_clr", tc_done, 0);
        en = 1'b1;
        tick();
        checkEq("eop_rearm", DREQ, 1);
        en = 1'b0;
        tick();
        checkEq("en_off_dreq", DREQ, 0);

        // Drain the 0x5A entry through a bus read
        en = 1'b1;
        tick();
        DACK_N = 1'b0;
        tick();
        IOR_N = 1'b0;
        tick();
        checkEq("drain_dbo", DB_O, 8'h5A);
        IOR_N = 1'b1; DACK_N = 1'b1;
        tick();
        en = 1'b0;
        tick();
        checkEq("drain_level", level, 0);

        // Demand-mode write of eight bytes
        dir = 1'b1; demand = 1'b1; en = 1'b1;
        tick();
        DACK_N = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            DB_I  = 8'(k);
            IOW_N = 1'b0;
            tick();
            IOW_N = 1'b1;
            tick();
            if (k == 6) checkEq("wr_dreq_7th", DREQ, 1);
        end
        tick();
        checkEq("wr_dreq_drop", DREQ, 0);
        checkEq("wr_level8", level, 8);
        checkEq("wr_err0", err, 0);

        // Overrun: one more write into a full FIFO
        DB_I  = 8'hEE;
        IOW_N = 1'b0;
        tick();
        IOW_N = 1'b1; DACK_N = 1'b1;
        tick();
        checkEq("ovr_err", err, 1);
        checkEq("ovr_level", level, 8);

        // Core drains the write data in order
        en = 1'b0;
        snk_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkEq("snk_data", snk_data, 32'(k));
            tick();
        end
        snk_ready = 1'b0;
        checkEq("snk_level0", level, 0);
        checkEq("snk_valid0", snk_valid, 0);

        // Underrun: demand read continues past the last entry
        dir = 1'b0;
        tick();
        corePush(8'h77);
        en = 1'b1;
        tick();
        DACK_N = 1'b0;
        tick();
        IOR_N = 1'b0;
        tick();
        checkEq("udr_dbo_77", DB_O, 8'h77);
        IOR_N = 1'b1;
        tick();
        IOR_N = 1'b0;
        tick();
        checkEq("udr_dbo_ff", DB_O, 8'hFF);
        checkEq("udr_err", err, 1);
        IOR_N = 1'b1; DACK_N = 1'b1;
        tick();
        checkEq("udr_level", level, 0);

        // Reset asserted in the middle of a read strobe
        demand = 1'b0;
        corePush(8'h11);
        tick();
        DACK_N = 1'b0;
        tick();
        IOR_N = 1'b0;
        tick();
        checkEq("mid_dboe", DB_OE, 1);
        RESET_N = 1'b0;
        #2;
        checkEq("arst_dboe", DB_OE, 0);
        checkEq("arst_dreq", DREQ, 0);
        checkEq("arst_level", level, 0);
        checkEq("arst_eopo", EOP_N_O, 1);
        checkEq("arst_err", err, 0);
        IOR_N = 1'b1; DACK_N = 1'b1; en = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();

`ifdef DMA_PERIPH_EOP_GEN_EN
        // Generated EOP after three writes
        dir = 1'b1; demand = 1'b1; en = 1'b1; tc_count = 16'd3;
        tick();
        DACK_N = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            DB_I  = 8'(8'h40 + k);
            IOW_N = 1'b0;
            tick();
            IOW_N = 1'b1;
            tick();
            if (k < 2) checkEq("gen_eop_idle", EOP_N_O, 1);
        end
        checkEq("gen_eop_low", EOP_N_O, 0);
        checkEq("gen_tc", tc_done, 1);
        DACK_N = 1'b1;
        tick();
        checkEq("gen_eop_release", EOP_N_O, 1);
        checkEq("gen_dreq", DREQ, 0);
        checkEq("gen_level", level, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dma_periph_responder.md
Name: dma_periph_responder

Overview:
- Single-channel DMA peripheral endpoint. It sits at the far end of the 8237A-style DMA timing controller.
- Raises DREQ and waits for DACK_N. Responds to the controller's IOR_N/IOW_N strobes on the shared data bus. Samples or drives EOP_N.
- Buffers data between the DMA bus and the device core in a FIFO:
  - dir=0: device-to-memory, DMA write transfer (IOR).
  - dir=1: memory-to-device, DMA read transfer (IOW).

Parameters:
- DW, 8, data bus width.
- DEPTH, 8, FIFO depth in entries; power of two, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width.

Ports:
- CLK  in  1  system clock, the same clock as the DMA controller.
- RESET_N  in  1  asynchronous active-low reset.
- en  in  1  channel enable from the device core.
- dir  in  1  0 = device-to-memory, 1 = memory-to-device; sampled only in IDLE.
- demand  in  1  0 = single mode, 1 = demand mode.
- DREQ  out  1  DMA request to the controller, active-high.
- DACK_N  in  1  DMA acknowledge, active-low.
- IOR_N  in  1  I/O read strobe, active-low.
- IOW_N  in  1  I/O write strobe, active-low.
- DB_I  in  DW  data bus input.
- DB_O  out  DW  data bus output.
- DB_OE  out  1  data bus output enable.
- EOP_N_I  in  1  end-of-process from the controller, active-low.
- EOP_N_O  out  1  open-drain emulation of EOP: 0 = pull low, 1 = released.
- src_valid, src_ready, src_data  in/out/in  1/1/DW  device core push interface (dir=0).
- snk_valid, snk_ready, snk_data  out/in/out  1/1/DW  device core pop interface (dir=1).
- tc_done  out  1  sticky flag: EOP seen.
- err  out  1  sticky flag: FIFO underrun or overrun on the bus.
- level  out  AW+1  FIFO occupancy.

Behaviour:
- Reset values: DREQ=0, DB_OE=0, DB_O=0, EOP_N_O=1, tc_done=0, err=0, FIFO empty, level=0, snk_valid=0, state=IDLE.
- All bus inputs (DACK_N, IOR_N, IOW_N, EOP_N_I) are sampled on posedge CLK. Each strobe edge is detected against a one-cycle registered copy of that strobe.
- State machine:
  - IDLE -> REQ when en=1, tc_done=0 and the request condition holds. The request condition is level>0 for dir=0, or level<DEPTH for dir=1. dir is latched into dir_q on this transition.
  - REQ -> ACK when DACK_N=0 is sampled. DREQ is 1 in REQ. DREQ rises one cycle after the IDLE->REQ decision.
  - ACK -> STB on a strobe falling edge with DACK_N=0. The strobe is IOR_N if dir_q=0, IOW_N if dir_q=1. The other strobe is ignored.
  - STB -> ACK on the strobe rising edge, when demand=1, en=1 and the request condition still holds.
  - STB -> IDLE on the strobe rising edge in all other cases.
  - ACK -> IDLE when DACK_N returns high without a strobe.
- DREQ timing:
  - Single mode: DREQ falls in the cycle after DACK_N=0 is sampled.
  - Demand mode: DREQ stays 1 through ACK/STB while the request condition holds. It falls the cycle after the condition fails.
- Read cycle (dir_q=0):
  - DB_OE=1 and DB_O=FIFO head from the IOR_N falling edge until the IOR_N rising edge.
  - The FIFO pops on the IOR_N rising edge.
  - If the FIFO is empty: DB_O='1, no pop, err set.
- Write cycle (dir_q=1):
  - DB_I is captured every cycle while IOW_N=0.
  - The last captured value is pushed on the IOW_N rising edge.
  - If the FIFO is full: the value is dropped and err is set.
- The FIFO supports a core-side and a bus-side access in the same cycle. level is unchanged when a push and a pop coincide. Pointers wrap modulo DEPTH.
- EOP_N_I=0 sampled while DACK_N=0, in any of REQ/ACK/STB:
  - tc_done is set and DREQ=0 next cycle.
  - A strobe in flight completes its push or pop at its rising edge, then the block goes to IDLE.
  - EOP_N_I=0 outside DACK is ignored.
- en=0:
  - In IDLE or REQ: go to IDLE next cycle, DREQ=0.
  - In ACK or STB: finish the current strobe, then go to IDLE.
- tc_done and err clear only when en=0 in IDLE.
- Core interface: src_ready = (level<DEPTH) when dir_q=0. snk_valid = (level>0) when dir_q=1. The core side is blocked in the opposite direction.
- RESET_N assertion mid-transfer: all state clears immediately and DB_OE drops asynchronously.

Optional Feature:
- Macro: DMA_PERIPH_EOP_GEN_EN.
- When defined, the block adds:
  - Input tc_count[15:0], latched on IDLE->REQ.
  - A down-counter decremented on each completed strobe.
- When the counter reaches 0 on a strobe rising edge, EOP_N_O=0 for exactly one cycle. tc_done is then set and the block goes to IDLE, as for EOP_N_I.
- tc_count=0 means 65536 transfers.
- When not defined, EOP_N_O is tied to 1 and there is no counter logic.

Test Plan:
- Reset: hold RESET_N=0 mid-STB -> DREQ=0, DB_OE=0, level=0, EOP_N_O=1 immediately.
- Single-mode read: push 0xA5 and 0x3C via src, dir=0, en=1 -> DREQ=1; DACK_N=0 -> DREQ=0 next cycle; IOR_N pulse -> DB_O=0xA5 with DB_OE=1 during the pulse; after the rising edge level=1 and a second DREQ follows.
- Demand-mode write: dir=1, DEPTH=8, demand=1, eight IOW_N pulses with DB_I=0x00..0x07 under DACK_N=0 -> DREQ stays 1 through the seventh pulse and drops after the eighth; snk pops 0x00..0x07 in order; err=0.
- Overrun and underrun: an IOW_N pulse with level=8 -> err=1, level stays 8; an IOR_N pulse with level=0 -> DB_O=0xFF, err=1.
- External EOP: EOP_N_I=0 during the second IOR_N low phase -> that pop completes, tc_done=1, DREQ=0, state IDLE, no further DREQ until en toggles low.
- With DMA_PERIPH_EOP_GEN_EN: tc_count=3, dir=1 -> EOP_N_O low for one cycle after the third IOW_N rising edge, then tc_done=1.
